// File: rtl/dcfifo_rd_ctrl.sv
// Read-side controller for the dual-clock M20K FIFO: write-pointer sync, read sequencing, show-ahead output.
// Optional macro DCFIFO_RD_USEDW_EN adds the registered rdusedw fill-level output.
module dcfifo_rd_ctrl #(
   parameter int WIDTH       = 32,
   parameter int AW          = 9,
   parameter int RAM_LAT     = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic [AW:0]      wr_ptr_gray,
   output logic [AW:0]      rd_ptr_gray,
   output logic             ram_rden,
   output logic [AW-1:0]    ram_rdaddr,
   input  logic [WIDTH-1:0] ram_q,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             empty
`ifdef DCFIFO_RD_USEDW_EN
   ,
   output logic [AW+1:0]    rdusedw
`endif
);

   localparam int OB = RAM_LAT + 1;
   localparam int IW = (OB > 1) ? $clog2(OB) : 1;
   localparam int CW = 4;

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
      return (i == IW'(OB - 1)) ? '0 : i + 1'b1;
   endfunction

   logic [AW:0]       sync_q [SYNC_STAGES];
   logic [AW:0]       sync_d [SYNC_STAGES];
   logic [AW:0]       rbin_q, rbin_d, rbin_inc;
   logic [AW:0]       rd_gray_q, rd_gray_d;
   logic [AW:0]       wbin, avail;
   logic [RAM_LAT-1:0] vpipe_q, vpipe_d;
   logic [WIDTH-1:0]  obuf_q [OB];
   logic [WIDTH-1:0]  obuf_d [OB];
   logic [IW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     occ_q, occ_d, infl;
   logic              issue, pop, cap;

   always_comb begin
      sync_d[0] = wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   assign wbin     = gray2bin(sync_q[SYNC_STAGES-1]);
   assign avail    = wbin - rbin_q;
   assign rbin_inc = rbin_q + (AW+1)'(1);

   assign dout_valid = (occ_q != '0);
   assign empty      = ~dout_valid;
   assign dout       = obuf_q[head_q];
   assign pop        = dout_valid & dout_ready;
   assign cap        = vpipe_q[RAM_LAT-1];

   // Slots promised to in-flight reads count as used, so a returning word always has a home.
   always_comb begin
      infl = '0;
      for (int i = 0; i < RAM_LAT; i++) infl = infl + CW'(vpipe_q[i]);
   end

   assign issue      = (avail != '0) && ((occ_q + infl - CW'(pop)) < CW'(OB));
   assign ram_rden   = issue;
   assign ram_rdaddr = rbin_q[AW-1:0];
   assign rd_ptr_gray = rd_gray_q;

   always_comb begin
      rbin_d    = rbin_q;
      rd_gray_d = rd_gray_q;
      if (issue) begin
         rbin_d    = rbin_inc;
         rd_gray_d = bin2gray(rbin_inc);
      end

      vpipe_d[0] = issue;
      for (int i = 1; i < RAM_LAT; i++) vpipe_d[i] = vpipe_q[i-1];

      obuf_d = obuf_q;
      tail_d = tail_q;
      head_d = head_q;
      if (cap) begin
         obuf_d[tail_q] = ram_q;
         tail_d         = idx_inc(tail_q);
      end
      if (pop) head_d = idx_inc(head_q);

      occ_d = occ_q + CW'(cap) - CW'(pop);
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         for (int i = 0; i < OB; i++) obuf_q[i] <= '0;
         rbin_q    <= '0;
         rd_gray_q <= '0;
         vpipe_q   <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         occ_q     <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
         for (int i = 0; i < OB; i++) obuf_q[i] <= obuf_d[i];
         rbin_q    <= rbin_d;
         rd_gray_q <= rd_gray_d;
         vpipe_q   <= vpipe_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         occ_q     <= occ_d;
      end
   end

`ifdef DCFIFO_RD_USEDW_EN
   logic [AW+1:0] usedw_q, usedw_d;

   always_comb begin
      usedw_d = (AW+2)'(avail) + (AW+2)'(infl) + (AW+2)'(occ_q);
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) usedw_q <= '0;
      else      usedw_q <= usedw_d;
   end

   assign rdusedw = usedw_q;
`endif

endmodule
